dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single-port DRAM (async read, sync write) between the miniCPU data port and an on-board
//  debug requester (UART loader / memory inspector). The CPU owns DRAM by default. A debug access stalls
//  the CPU for 2 cycles, performs one word access, acks, then guarantees the CPU a holdoff window.
//  Also performs unified-address translation, CPU byte address -> DRAM word index, and out-of-range suppression.
// PARAMETERS
//  BASE_ADDR  32'h0000_4000  CPU byte address mapped to DRAM word 0
//  AW         14             DRAM word-address width (DRAM size = 4*2^AW bytes)
//  HOLDOFF    2              CPU-owned cycles forced after each debug ack (0 = none)
// PORTS
//  clk        in   1   system clock (CPU clock domain)
//  rst_n      in   1   synchronous active-low reset
//  cpu_we     in   1   CPU store enable
//  cpu_addr   in   32  CPU byte address (ALU result)
//  cpu_wdata  in   32  CPU store data
//  cpu_rdata  out  32  load data to CPU (combinational)
//  cpu_stall  out  1   1 = CPU must hold PC/RF (registered, from state)
//  dbg_req    in   1   debug request; held high with dbg_we/addr/wdata stable until dbg_ack
//  dbg_we     in   1   1 = write, 0 = read
//  dbg_addr   in   AW  DRAM word index
//  dbg_wdata  in   32  debug write data
//  dbg_ack    out  1   one-cycle completion pulse
//  dbg_rdata  out  32  read data, valid in the dbg_ack cycle and held until the next ack
//  dram_we    out  1   DRAM write enable
//  dram_a     out  AW  DRAM word address
//  dram_d     out  32  DRAM write data
//  dram_spo   in   32  DRAM async read data
//  oor_cnt    out  8   saturating count of suppressed out-of-range CPU stores
// BEHAVIOUR
//  Reset: state=S_CPU, cpu_stall=0, dbg_ack=0, dbg_rdata=0, oor_cnt=0, holdoff counter=0.
//  Translation: off=cpu_addr-BASE_ADDR (32-bit wrap); in_range = (cpu_addr>=BASE_ADDR) && (off < 4*2^AW);
//   cpu word = off[AW+1:2]; off[1:0] is ignored (word accesses only).
//  States:
//  - S_CPU: DRAM driven by CPU: dram_a=cpu word, dram_d=cpu_wdata, dram_we=cpu_we&in_range.
//    dbg_req=1 -> S_STALL. The CPU instruction in this cycle completes normally.
//  - S_STALL: cpu_stall=1, dram_we=0. dbg_req=1 -> S_DBG; dbg_req=0 (abort) -> S_CPU, no ack.
//  - S_DBG: cpu_stall=1; dram_a=dbg_addr, dram_d=dbg_wdata, dram_we=dbg_we. dbg_rdata<=dram_spo on the
//    closing edge, reads only; writes leave dbg_rdata unchanged. Completes even if dbg_req drops.
//    -> S_ACK.
//  - S_ACK: dbg_ack=1, cpu_stall=1, dram_we=0. -> S_HOLD, counter=HOLDOFF-1, if HOLDOFF>0; else -> S_CPU.
//  - S_HOLD: DRAM driven as in S_CPU, cpu_stall=0; dbg_req is ignored. At counter=0 -> S_CPU, else decrement.
//  - Read data: cpu_rdata = dram_spo when in_range and state is S_CPU/S_HOLD, else 32'h0.
//  - Latency: req sampled high at edge k -> ack high in cycle k+3. Stall covers cycles k+1..k+3.
//  - Back-to-back: requester drops dbg_req in the cycle after the ack. A still-high dbg_req is a new
//    request once S_CPU is re-entered.
//  - oor_cnt increments on every S_CPU/S_HOLD cycle with cpu_we=1 && !in_range, and saturates at 8'hFF.
//  - Synchronous reset in any state aborts an in-flight access: no ack, and the DRAM write is issued
//    only if the reset edge comes after the S_DBG cycle.
// TESTING
//  1 cpu_we=1, cpu_addr=0x4008, wdata=0x25000018 -> dram_we=1, dram_a=2; cpu_rdata=dram_spo same cycle.
//  2 cpu_we=1, cpu_addr=0x3FFC, then 0x14000 (AW=14) -> dram_we=0 both, oor_cnt=2, cpu_rdata=0.
//  3 dbg read addr=5 (DRAM[5]=0xDEADBEEF), dbg_req at edge k -> stall k+1..k+3, ack at k+3,
//    dbg_rdata=0xDEADBEEF, dram_we=0 throughout.
//  4 dbg write addr=7 data=0x12345678 with cpu_we=1 held high -> exactly one DRAM write (dram_a=7) in S_DBG;
//    with HOLDOFF=2, the CPU runs 2 unstalled cycles before the next req is granted.
//  5 dbg_req raised then dropped during S_STALL -> back to S_CPU, no ack, no DRAM write.
//  6 rst_n=0 during S_DBG -> next cycle state S_CPU, stall=0, ack=0, oor_cnt=0.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the DRAM arbiter and its neighbours: CPU data port, debug requester and DRAM.
// The arbiter takes the slave view; the surroundings (CPU, debug port, DRAM) take the master view.
interface dram_arbiter_if #(
  parameter int AW = 14
);
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic          dbg_ack;
  logic [31:0]   dbg_rdata;

  logic          dram_we;
  logic [AW-1:0] dram_a;
  logic [31:0]   dram_d;
  logic [31:0]   dram_spo;

  logic [7:0]    oor_cnt;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, dram_spo,
    output cpu_rdata, cpu_stall, dbg_ack, dbg_rdata, dram_we, dram_a, dram_d, oor_cnt
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, dram_spo,
    input  cpu_rdata, cpu_stall, dbg_ack, dbg_rdata, dram_we, dram_a, dram_d, oor_cnt
  );
endinterface

// File: rtl/dram_arbiter.sv
// Shares a single-port DRAM between the CPU data port (default owner) and a debug requester,
// translating CPU byte addresses to DRAM word indices and suppressing out-of-range stores.
module dram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int          AW        = 14,
  parameter int          HOLDOFF   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  dram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_CPU,
    S_STALL,
    S_DBG,
    S_ACK,
    S_HOLD
  } state_e;

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   dbg_rdata_q, dbg_rdata_d;
  logic [7:0]    oor_q, oor_d;

  logic [31:0]   off;
  logic          in_range;
  logic          cpu_owned;
  logic [AW-1:0] cpu_word;
  logic          unused_off_lsb;

  // The window test relies on 32-bit wrap: addresses below BASE_ADDR wrap to huge offsets.
  assign off            = bus.cpu_addr - BASE_ADDR;
  assign in_range       = (bus.cpu_addr >= BASE_ADDR) && (off[31:AW+2] == '0);
  assign cpu_word       = off[AW+1:2];
  assign unused_off_lsb = ^off[1:0];
  assign cpu_owned      = (state_q == S_CPU) || (state_q == S_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_CPU;
      hold_q      <= '0;
      dbg_rdata_q <= '0;
      oor_q       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      hold_q      <= hold_d;
      dbg_rdata_q <= dbg_rdata_d;
      oor_q       <= oor_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a _d signal unassigned (no inferred latch).
    state_d     = state_q;
    hold_d      = hold_q;
    dbg_rdata_d = dbg_rdata_q;
    oor_d       = oor_q;
    unique case (state_q)
      S_CPU:   if (bus.dbg_req) state_d = S_STALL;
      S_STALL: state_d = bus.dbg_req ? S_DBG : S_CPU;
      S_DBG: begin
        state_d = S_ACK;
        if (!bus.dbg_we) dbg_rdata_d = bus.dram_spo;
      end
      S_ACK: begin
        if (HOLDOFF > 0) begin
          state_d = S_HOLD;
          hold_d  = HW'(HOLDOFF - 1);
        end else begin
          state_d = S_CPU;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_CPU;
        else              hold_d  = hold_q - HW'(1);
      end
      default: state_d = S_CPU;
    endcase
    if (cpu_owned && bus.cpu_we && !in_range && (oor_q != 8'hFF)) oor_d = oor_q + 8'd1;
  end

  always_comb begin
    bus.cpu_stall = (state_q == S_STALL) || (state_q == S_DBG) || (state_q == S_ACK);
    bus.dbg_ack   = (state_q == S_ACK);
    bus.dram_a    = cpu_word;
    bus.dram_d    = bus.cpu_wdata;
    bus.dram_we   = 1'b0;
    if (cpu_owned) begin
      bus.dram_we = bus.cpu_we & in_range;
    end else if (state_q == S_DBG) begin
      bus.dram_a  = bus.dbg_addr;
      bus.dram_d  = bus.dbg_wdata;
      bus.dram_we = bus.dbg_we;
    end
    bus.cpu_rdata = (cpu_owned && in_range) ? bus.dram_spo : 32'h0;
  end

  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.oor_cnt   = oor_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: randomized CPU/debug traffic against a word-level memory
// model and the per-cycle debug access timeline (stall k+1..k+3, ack k+3, write in k+2, holdoff after).
module tb_dram_arbiter;
  localparam int          AW      = 14;
  localparam logic [31:0] BASE    = 32'h0000_4000;
  localparam int          HOLDOFF = 2;
  localparam int          DEPTH   = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_arbiter_if #(.AW(AW)) bus ();

  dram_arbiter #(.BASE_ADDR(BASE), .AW(AW), .HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // DRAM itself: asynchronous read, synchronous write.
  logic [31:0] mem [DEPTH];
  assign bus.dram_spo = mem[bus.dram_a];
  always @(posedge clk) if (bus.dram_we) mem[bus.dram_a] <= bus.dram_d;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [int];
  int          exp_oor = 0;
  logic [31:0] exp_dbg_rdata = 32'h0;

  function automatic bit in_rng(input logic [31:0] a);
    longint o = longint'(a) - longint'(BASE);
    return (o >= 0) && (o < 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] addr_of(input int w);
    return BASE + 32'(w) * 4 + 32'($urandom % 4);
  endfunction

  function automatic int pick_word();
    int r = int'($urandom % 16);
    return ($urandom % 2 == 0) ? r : DEPTH - 16 + r;
  endfunction

  function automatic logic [31:0] oor_addr();
    case ($urandom % 4)
      0:       return $urandom_range(BASE - 1, 0);
      1:       return BASE + 32'(4 * DEPTH) + ($urandom % 4096);
      2:       return 32'hFFFF_FFFC;
      default: return $urandom | 32'h0002_0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (!in_rng(a)) return 32'h0;
    if (ref_mem.exists(word_of(a))) return ref_mem[word_of(a)];
    return 32'h0;
  endfunction

  function automatic void cpu_commit(input bit we, input logic [31:0] a, input logic [31:0] d);
    if (we) begin
      if (in_rng(a)) ref_mem[word_of(a)] = d;
      else if (exp_oor < 255) exp_oor++;
    end
  endfunction

  // One CPU-owned cycle; called with the clock just past a rising edge.
  task automatic cpu_cycle(input bit we, input logic [31:0] a, input logic [31:0] d, input string tag);
    bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    checks++;
    if ({bus.cpu_stall, bus.dbg_ack, bus.dram_we, bus.cpu_rdata} !==
        {1'b0, 1'b0, we && in_rng(a), exp_rd(a)}) begin
      errors++;
      $display("FAIL %s cpu addr=%h: stall/ack/we=%b%b%b rdata=%h, expected 00%b rdata=%h",
               tag, a, bus.cpu_stall, bus.dbg_ack, bus.dram_we, bus.cpu_rdata,
               we && in_rng(a), exp_rd(a));
    end
    if (we && in_rng(a)) begin
      checks++;
      if ({bus.dram_a, bus.dram_d} !== {AW'(word_of(a)), d}) begin
        errors++;
        $display("FAIL %s dram addr/data: got %0d/%h expected %0d/%h",
                 tag, bus.dram_a, bus.dram_d, word_of(a), d);
      end
    end
    @(posedge clk); #1;
    cpu_commit(we, a, d);
  endtask

  // One debug access starting in a CPU-owned cycle (k), walked through the timeline to the end of
  // the holdoff window. With keep_req the request stays high as a back-to-back request.
  task automatic do_dbg(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        input bit cwe, input logic [31:0] ca, input logic [31:0] cd,
                        input bit keep_req, input string tag);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    for (int c = 0; c <= 3 + HOLDOFF; c++) begin
      bit          owned = (c == 0) || (c >= 4);
      bit          e_we  = owned ? (cwe && in_rng(ca)) : ((c == 2) ? we : 1'b0);
      logic [31:0] e_rd  = owned ? exp_rd(ca) : 32'h0;
      @(negedge clk);
      checks++;
      if ({bus.cpu_stall, bus.dbg_ack, bus.dram_we, bus.cpu_rdata} !==
          {!owned, c == 3, e_we, e_rd}) begin
        errors++;
        $display("FAIL %s cycle k+%0d: stall/ack/we=%b%b%b rdata=%h, expected %b%b%b rdata=%h",
                 tag, c, bus.cpu_stall, bus.dbg_ack, bus.dram_we, bus.cpu_rdata,
                 !owned, c == 3, e_we, e_rd);
      end
      if (c == 2) begin
        checks++;
        if (bus.dram_a !== a || (we && bus.dram_d !== d)) begin
          errors++;
          $display("FAIL %s debug dram addr/data: got %0d/%h expected %0d/%h",
                   tag, bus.dram_a, bus.dram_d, a, d);
        end
      end
      if (c >= 3) begin
        checks++;
        if (bus.dbg_rdata !== exp_dbg_rdata) begin
          errors++;
          $display("FAIL %s dbg_rdata at k+%0d: got %h expected %h", tag, c, bus.dbg_rdata, exp_dbg_rdata);
        end
      end
      @(posedge clk); #1;
      if (owned) cpu_commit(cwe, ca, cd);
      if (c == 2) begin
        if (we) ref_mem[int'(a)] = d;
        else    exp_dbg_rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
      end
      if (c == 3 && !keep_req) bus.dbg_req = 1'b0;
    end
    checks++;
    if (bus.oor_cnt !== 8'(exp_oor)) begin
      errors++;
      $display("FAIL %s oor_cnt: got %0d expected %0d", tag, bus.oor_cnt, exp_oor);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.cpu_stall, bus.dbg_ack, bus.dram_we, bus.dbg_rdata, bus.oor_cnt} !== {3'b000, 32'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset: stall/ack/we=%b%b%b dbg_rdata=%h oor=%0d, expected 000 0 0",
               bus.cpu_stall, bus.dbg_ack, bus.dram_we, bus.dbg_rdata, bus.oor_cnt);
    end
    rst_n = 1'b1;
    exp_oor = 0; exp_dbg_rdata = 32'h0;
    cpu_cycle(1'b0, 32'h0, 32'h0, "reset_idle");
  endtask

  task automatic init_pool();
    for (int i = 0; i < 16; i++) begin
      cpu_cycle(1'b1, addr_of(i), $urandom, "init_lo");
      cpu_cycle(1'b1, addr_of(DEPTH - 16 + i), $urandom, "init_hi");
    end
  endtask

  task automatic test_cpu_map();
    cpu_cycle(1'b1, 32'h0000_4008, 32'h2500_0018, "map_spec");
    cpu_cycle(1'b0, 32'h0000_4008, 32'h0, "map_spec_rb");
    checks++;
    if (bus.cpu_rdata !== 32'h2500_0018) begin
      errors++;
      $display("FAIL map_spec_value: got %h expected 25000018", bus.cpu_rdata);
    end
    cpu_cycle(1'b1, BASE + 32'(4 * DEPTH) - 32'd4, 32'hA5A5_0001, "map_top");
    cpu_cycle(1'b0, BASE + 32'(4 * DEPTH) - 32'd1, 32'h0, "map_top_rb");
    for (int i = 0; i < 40; i++)
      cpu_cycle(1'($urandom % 2), addr_of(pick_word()), $urandom, "map_rand");
  endtask

  task automatic test_oor();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_oor = 0; exp_dbg_rdata = 32'h0;
    cpu_cycle(1'b1, 32'h0000_3FFC, 32'h1111_1111, "oor_below");
    cpu_cycle(1'b1, 32'h0001_4000, 32'h2222_2222, "oor_above");
    checks++;
    if (bus.oor_cnt !== 8'd2) begin
      errors++;
      $display("FAIL oor_spec_count: got %0d expected 2", bus.oor_cnt);
    end
    for (int i = 0; i < 20; i++) cpu_cycle(1'($urandom % 2), oor_addr(), $urandom, "oor_rand");
    checks++;
    if (bus.oor_cnt !== 8'(exp_oor)) begin
      errors++;
      $display("FAIL oor_rand_count: got %0d expected %0d", bus.oor_cnt, exp_oor);
    end
    for (int i = 0; i < 260; i++) cpu_cycle(1'b1, oor_addr(), $urandom, "oor_sat");
    checks++;
    if (bus.oor_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL oor_saturate: got %0d expected 255", bus.oor_cnt);
    end
  endtask

  task automatic test_dbg_read();
    cpu_cycle(1'b1, BASE + 32'd20, 32'hDEAD_BEEF, "dbg_read_preload");
    do_dbg(1'b0, AW'(5), $urandom, 1'b0, 32'h0, 32'h0, 1'b0, "dbg_read");
    checks++;
    if (bus.dbg_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dbg_read_value: got %h expected deadbeef", bus.dbg_rdata);
    end
  endtask

  // Debug write with the CPU storing throughout, then a second request held high through the
  // holdoff: the CPU keeps HOLDOFF unstalled cycles plus the cycle in which the new request is sampled.
  task automatic test_back_to_back();
    do_dbg(1'b1, AW'(7), 32'h1234_5678, 1'b1, addr_of(3), $urandom, 1'b1, "dbg_write_b2b");
    do_dbg(1'b0, AW'(7), $urandom, 1'b1, addr_of(4), $urandom, 1'b0, "b2b_read");
    checks++;
    if (bus.dbg_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_read_value: got %h expected 12345678", bus.dbg_rdata);
    end
    cpu_cycle(1'b0, addr_of(7), 32'h0, "dbg_write_cpu_rb");
  endtask

  task automatic test_abort();
    logic [31:0] held = bus.dbg_rdata;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = AW'(3); bus.dbg_wdata = ~ref_mem[3];
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_stall, bus.dbg_ack, bus.dram_we} !== 3'b100) begin
      errors++;
      $display("FAIL abort_stall: stall/ack/we=%b%b%b expected 100", bus.cpu_stall, bus.dbg_ack, bus.dram_we);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) cpu_cycle(1'b0, 32'h0, 32'h0, "abort_after");
    cpu_cycle(1'b0, addr_of(3), 32'h0, "abort_rb");
    checks++;
    if (bus.dbg_rdata !== held) begin
      errors++;
      $display("FAIL abort_rdata: got %h expected %h", bus.dbg_rdata, held);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d = $urandom;
    cpu_cycle(1'b1, 32'h0, 32'h1, "rm_oor");
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = AW'(9); bus.dbg_wdata = d;
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if ({bus.cpu_stall, bus.dram_we, bus.dram_a} !== {2'b11, AW'(9)}) begin
      errors++;
      $display("FAIL rm_in_dbg: stall/we=%b%b addr=%0d expected 11 addr=9", bus.cpu_stall, bus.dram_we, bus.dram_a);
    end
    rst_n = 1'b0; bus.dbg_req = 1'b0;
    @(posedge clk); #1;
    ref_mem[9] = d;
    exp_oor = 0; exp_dbg_rdata = 32'h0;
    checks++;
    if ({bus.cpu_stall, bus.dbg_ack, bus.oor_cnt, bus.dbg_rdata} !== {2'b00, 8'h0, 32'h0}) begin
      errors++;
      $display("FAIL rm_after_reset: stall/ack=%b%b oor=%0d dbg_rdata=%h expected 00 0 0",
               bus.cpu_stall, bus.dbg_ack, bus.oor_cnt, bus.dbg_rdata);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cpu_cycle(1'b0, 32'h0, 32'h0, "rm_idle");
    cpu_cycle(1'b0, addr_of(9), 32'h0, "rm_rb");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ca = ($urandom % 4 == 0) ? oor_addr() : addr_of(pick_word());
      case ($urandom % 3)
        0: cpu_cycle(1'($urandom % 2), ca, $urandom, "rand_cpu");
        1: do_dbg(1'($urandom % 2), AW'(pick_word()), $urandom, 1'($urandom % 2), ca, $urandom,
                  1'b0, "rand_dbg");
        default: begin
          do_dbg(1'($urandom % 2), AW'(pick_word()), $urandom, 1'($urandom % 2), ca, $urandom,
                 1'b1, "rand_b2b_1");
          do_dbg(1'($urandom % 2), AW'(pick_word()), $urandom, 1'($urandom % 2), ca, $urandom,
                 1'b0, "rand_b2b_2");
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    init_pool();
    test_cpu_map();
    test_oor();
    test_dbg_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog expired");
  end
endmodule
